// File: rtl/mac_pkg.sv
// ============================================================================
// Module      : mac_pkg
// Description : Shared types and constants for the MAC array feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREFETCH = 3'd1,
    GAP      = 3'd2,
    CONV     = 3'd3,
    DRAIN    = 3'd4,
    FIN      = 3'd5
  } state_t;

  localparam int c_A_W = 16;
  localparam int c_W_W = 8;
  localparam int c_P_W = 40;

  // Cycles needed after the last vector until every PE has seen a zero.
  function automatic int drain_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_array_feeder_skew.sv
// ============================================================================
// Module      : mac_skew_line
// Description : Enable-gated A_W-wide delay line of DEPTH stages (0 = wire).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_skew_line #(
  parameter int A_W   = 16,
  parameter int DEPTH = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [A_W-1:0] d,
  output logic [A_W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst_n, en};
    assign q = d;
  end else begin : g_shift
    logic [A_W-1:0] r_sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
      end else if (en) begin
        r_sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
    end

    assign q = r_sr[DEPTH-1];
  end

endmodule

`default_nettype wire

// File: rtl/mac_array_feeder.sv
// ============================================================================
// Module      : mac_array_feeder
// Description : Loads a weight tile, streams skewed activations and drains a
//               weight-stationary MAC array. Optional MAC_FEEDER_STALL_CNT_EN
//               adds a 32-bit CONV stall counter output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_array_feeder
  import mac_pkg::*;
#(
  parameter int ROWS  = 3,
  parameter int COLS  = 3,
  parameter int A_W   = c_A_W,
  parameter int W_W   = c_W_W,
  parameter int P_W   = c_P_W,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_vec,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [COLS*W_W-1:0] w_data,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ROWS*A_W-1:0] a_data,
  output logic                arr_prefetch,
  output logic                arr_conv,
  output logic [COLS*W_W-1:0] arr_w,
  output logic [ROWS*A_W-1:0] arr_a,
  output logic [COLS*P_W-1:0] arr_p,
  output logic                busy,
`ifdef MAC_FEEDER_STALL_CNT_EN
  output logic [31:0]         stall_cnt,
`endif
  output logic                done
);

  localparam int c_DRAIN  = drain_len(ROWS, COLS);
  localparam int c_DCNT_W = $clog2(c_DRAIN + 1);
  localparam int c_WCNT_W = $clog2(ROWS + 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_remain;
  logic [c_WCNT_W-1:0]   r_wcnt;
  logic [c_DCNT_W-1:0]   r_dcnt;
  logic                  r_w_ready;
  logic                  r_a_ready;
  logic                  r_prefetch;
  logic                  r_conv;
  logic                  r_busy;
  logic                  r_done;
  logic [COLS*W_W-1:0]   r_arr_w;

  logic w_drain;
  logic w_shift;

  assign w_drain = (r_state == DRAIN);
  // Skew lines move exactly when arr_conv is being loaded with 1.
  assign w_shift = (r_state == CONV && a_valid) || w_drain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_remain   <= '0;
      r_wcnt     <= '0;
      r_dcnt     <= '0;
      r_w_ready  <= 1'b0;
      r_a_ready  <= 1'b0;
      r_prefetch <= 1'b0;
      r_conv     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_arr_w    <= '0;
    end else begin
      r_prefetch <= 1'b0;
      r_conv     <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_remain  <= num_vec;
            r_wcnt    <= '0;
            r_w_ready <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= PREFETCH;
          end
        end
        PREFETCH: begin
          if (w_valid) begin
            r_arr_w    <= w_data;
            r_prefetch <= 1'b1;
            if (r_wcnt == c_WCNT_W'(ROWS - 1)) begin
              r_wcnt    <= '0;
              r_w_ready <= 1'b0;
              r_state   <= GAP;
            end else begin
              r_wcnt <= r_wcnt + c_WCNT_W'(1);
            end
          end
        end
        GAP: begin
          if (r_remain == '0) begin
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_a_ready <= 1'b1;
            r_state   <= CONV;
          end
        end
        CONV: begin
          if (a_valid) begin
            r_conv   <= 1'b1;
            r_remain <= r_remain - CNT_W'(1);
            // Counting down to one keeps an all-ones job from wrapping.
            if (r_remain == CNT_W'(1)) begin
              r_a_ready <= 1'b0;
              r_dcnt    <= '0;
              r_state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          r_conv <= 1'b1;
          if (r_dcnt == c_DCNT_W'(c_DRAIN - 1)) begin
            r_dcnt  <= '0;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_dcnt <= r_dcnt + c_DCNT_W'(1);
          end
        end
        FIN: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [A_W-1:0] w_head;
    logic [A_W-1:0] w_tail;
    logic [A_W-1:0] r_out;

    assign w_head = w_drain ? '0 : a_data[r*A_W +: A_W];

    mac_skew_line #(
      .A_W   (A_W),
      .DEPTH (r)
    ) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_shift),
      .d     (w_head),
      .q     (w_tail)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_out <= '0;
      else if (w_shift) r_out <= w_tail;
    end

    assign arr_a[r*A_W +: A_W] = r_out;
  end

`ifdef MAC_FEEDER_STALL_CNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         r_stall <= '0;
    else if (r_state == IDLE && start)                  r_stall <= '0;
    else if (r_state == CONV && !a_valid && r_stall != '1) r_stall <= r_stall + 32'd1;
  end

  assign stall_cnt = r_stall;
`endif

  assign w_ready      = r_w_ready;
  assign a_ready      = r_a_ready;
  assign arr_prefetch = r_prefetch;
  assign arr_conv     = r_conv;
  assign arr_w        = r_arr_w;
  assign arr_p        = '0;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mac_array_feeder.sv
// ============================================================================
// Module      : tb_mac_array_feeder
// Description : Scoreboard bench for mac_array_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_array_feeder;

  localparam int ROWS  = 3;
  localparam int COLS  = 3;
  localparam int A_W   = 16;
  localparam int W_W   = 8;
  localparam int P_W   = 40;
  localparam int CNT_W = 16;
  localparam int DRAIN = ROWS + COLS - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [CNT_W-1:0]    num_vec = '0;
  logic                w_valid = 1'b0;
  logic [COLS*W_W-1:0] w_data = '0;
  logic                a_valid = 1'b0;
  logic [ROWS*A_W-1:0] a_data = '0;
  logic                w_ready, a_ready, arr_prefetch, arr_conv, busy, done;
  logic [COLS*W_W-1:0] arr_w;
  logic [ROWS*A_W-1:0] arr_a;
  logic [COLS*P_W-1:0] arr_p;
`ifdef MAC_FEEDER_STALL_CNT_EN
  logic [31:0]         stall_cnt;
`endif

  always #5 clk = ~clk;

  mac_array_feeder #(
    .ROWS (ROWS), .COLS (COLS), .A_W (A_W), .W_W (W_W), .P_W (P_W), .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_vec      (num_vec),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_data       (a_data),
    .arr_prefetch (arr_prefetch),
    .arr_conv     (arr_conv),
    .arr_w        (arr_w),
    .arr_a        (arr_a),
    .arr_p        (arr_p),
    .busy         (busy),
`ifdef MAC_FEEDER_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
`endif
    .done         (done)
  );

  typedef struct packed {
    logic                pf;
    logic                cv;
    logic                dn;
    logic [COLS*W_W-1:0] w;
    logic [ROWS*A_W-1:0] a;
  } exp_t;

  exp_t                sb[$];
  exp_t                mon_e;
  int                  checks = 0;
  int                  failures = 0;
  logic [COLS*W_W-1:0] wbeat [ROWS];
  logic [ROWS*A_W-1:0] vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait expired, got timeout expected handshake (t=%0t)", name, $time);
  endtask

  // Row r at conv-cycle k carries row r of vector k-r, zero outside the job.
  function automatic logic [ROWS*A_W-1:0] exp_a(input int k, input int nv);
    logic [ROWS*A_W-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      if (k - r >= 0 && k - r < nv) v[r*A_W +: A_W] = vecs[k-r][r*A_W +: A_W];
    return v;
  endfunction

  task automatic push_prefetch();
    exp_t e;
    for (int b = 0; b < ROWS; b++) begin
      e = '0; e.pf = 1'b1; e.w = wbeat[b];
      sb.push_back(e);
    end
  endtask

  task automatic push_conv(input int nv);
    exp_t e;
    if (nv == 0) begin
      e = '0; e.dn = 1'b1;
      sb.push_back(e);
    end else begin
      for (int k = 0; k < nv + DRAIN; k++) begin
        e = '0; e.cv = 1'b1; e.dn = (k == nv + DRAIN - 1); e.a = exp_a(k, nv);
        sb.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    chk("ready_exclusive", {63'b0, w_ready & a_ready}, 64'd0);
    if (rst_n && (arr_prefetch || arr_conv || done)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got pf=%0b cv=%0b done=%0b expected nothing", arr_prefetch, arr_conv, done);
      end else begin
        mon_e = sb.pop_front();
        chk("arr_prefetch", {63'b0, arr_prefetch}, {63'b0, mon_e.pf});
        chk("arr_conv", {63'b0, arr_conv}, {63'b0, mon_e.cv});
        chk("done", {63'b0, done}, {63'b0, mon_e.dn});
        chk("busy", {63'b0, busy}, 64'd1);
        chk("arr_p", {63'b0, |arr_p}, 64'd0);
        if (mon_e.pf) chk("arr_w", 64'(arr_w), 64'(mon_e.w));
        if (mon_e.cv) chk("arr_a", 64'(arr_a), 64'(mon_e.a));
      end
    end
  end

  task automatic do_start(input int nv);
    start = 1'b1;
    num_vec = CNT_W'(nv);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_w(input logic [COLS*W_W-1:0] d);
    int n = 0;
    w_valid = 1'b1;
    w_data = d;
    while (!w_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!w_ready) timeout_fail("w_ready_wait");
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic send_a(input logic [ROWS*A_W-1:0] d);
    int n = 0;
    a_valid = 1'b1;
    a_data = d;
    while (!a_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!a_ready) timeout_fail("a_ready_wait");
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    if (busy) timeout_fail("job_end_wait");
  endtask

  task automatic run_job(input int nv, input int stall_at, input bit dup);
    push_prefetch();
    push_conv(nv);
    do_start(nv);
    for (int b = 0; b < ROWS; b++) begin
      send_w(wbeat[b]);
      if (dup && b == 0) do_start(5);
    end
    for (int i = 0; i < nv; i++) begin
      if (stall_at > 0 && i == stall_at) begin
        a_valid = 1'b0;
        repeat (2) begin
          @(posedge clk); #1;
          chk("stall_conv", {63'b0, arr_conv}, 64'd0);
          chk("stall_arr_a", 64'(arr_a), 64'(exp_a(i - 1, nv)));
        end
      end
      send_a(vecs[i]);
    end
    wait_idle();
  endtask

  initial begin
    wbeat[0] = 24'h31_21_03;
    wbeat[1] = 24'h32_22_02;
    wbeat[2] = 24'h33_23_01;
    vecs[0] = {16'd3, 16'd2, 16'd1};
    vecs[1] = {16'd6, 16'd5, 16'd4};
    vecs[2] = {16'd9, 16'd8, 16'd7};
    vecs[3] = {16'h00c, 16'h00b, 16'h00a};
    for (int i = 4; i < 8; i++) vecs[i] = '0;

    repeat (2) @(posedge clk); #1;
    chk("rst_arr_prefetch", {63'b0, arr_prefetch}, 64'd0);
    chk("rst_arr_conv", {63'b0, arr_conv}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_w_ready", {63'b0, w_ready}, 64'd0);
    chk("rst_a_ready", {63'b0, a_ready}, 64'd0);
    chk("rst_arr_w", 64'(arr_w), 64'd0);
    chk("rst_arr_a", 64'(arr_a), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_w_ready", {63'b0, w_ready}, 64'd0);

    // Prefetch 3,2,1 then GAP then done with no conv.
    run_job(0, 0, 1'b0);
    // Skew: {1,2,3},{4,5,6} back-to-back.
    run_job(2, 0, 1'b0);
    // Backpressure: two idle cycles before the third vector.
    run_job(4, 2, 1'b0);
`ifdef MAC_FEEDER_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'd2);
`endif
    // Start with num_vec=5 while busy must be ignored.
    run_job(2, 0, 1'b1);
    run_job(1, 0, 1'b0);

    // Reset while arr_conv is high.
    push_prefetch();
    do_start(3);
    for (int b = 0; b < ROWS; b++) send_w(wbeat[b]);
    send_a(vecs[0]);
    chk("pre_reset_conv", {63'b0, arr_conv}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_arr_conv", {63'b0, arr_conv}, 64'd0);
    chk("mid_rst_arr_a", 64'(arr_a), 64'd0);
    chk("mid_rst_arr_w", 64'(arr_w), 64'd0);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_done", {63'b0, done}, 64'd0);
    chk("mid_rst_a_ready", {63'b0, a_ready}, 64'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_done", {63'b0, done}, 64'd0);
    run_job(2, 0, 1'b0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
